image_stream_loader: RTL and testbench

Front-end stage that feeds the accelerator's image input. It receives pixels as a raster stream over a valid/ready handshake and assembles them into a full 28x28 frame, using two ping-pong frame banks. It presents one complete, stable frame while the next one fills, and releases a bank when the consumer acknowledges that it has sampled the frame.

---
 rtl/lenet_pkg.sv | 12 +
 rtl/raster_counter.sv | 51 +++++
 rtl/image_stream_loader.sv | 119 +++++++++++
 tb/tb_image_stream_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared constants and pixel/frame types for the LeNet accelerator front end.
package lenet_pkg;

    localparam int unsigned BITWIDTH    = 32;
    localparam int unsigned IMG_ROWS    = 28;
    localparam int unsigned IMG_COLS    = 28;
    localparam int unsigned FRAME_CNT_W = 32;

    typedef logic [BITWIDTH-1:0] pixel_t;
    typedef pixel_t frame_t [IMG_ROWS][IMG_COLS];

endpackage

// File: rtl/raster_counter.sv
// Row/column raster position counter with enable, wrap and end-of-frame flag.
module raster_counter #(
    parameter int unsigned ROWS = 28,
    parameter int unsigned COLS = 28
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    output logic [$clog2(ROWS)-1:0] row_o,
    output logic [$clog2(COLS)-1:0] col_o,
    output logic                    last_c_o
);

    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned COL_W = $clog2(COLS);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             col_wrap;

    assign col_wrap = (col_q == COL_W'(COLS - 1));
    assign last_c_o = col_wrap && (row_q == ROW_W'(ROWS - 1));

    // Advance one position per enabled cycle; the final position returns to origin.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (en_i) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = last_c_o ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o = row_q;
    assign col_o = col_q;

endmodule

// File: rtl/image_stream_loader.sv
// Ping-pong frame assembler: raster pixel stream in, stable full frame out.
// Optional frame_count output enabled by defining IMG_LOADER_FRAME_CNT_EN.
module image_stream_loader
    import lenet_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  pixel_t pix_data,
    input  logic   pix_valid,
    input  logic   pix_last,
    output logic   pix_ready,
    output frame_t image,
    output logic   frame_valid,
    input  logic   frame_ack,
    output logic   len_err
`ifdef IMG_LOADER_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_count
`endif
);

    localparam int unsigned ROW_W = $clog2(IMG_ROWS);
    localparam int unsigned COL_W = $clog2(IMG_COLS);

    frame_t           bank_q [2];
    logic [1:0]       full_q, full_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic             len_err_q, len_err_d;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             at_last;
    logic             accept;
    logic             frame_done;
    logic             ack_take;

    assign pix_ready  = reset && !full_q[wr_sel_q];
    assign accept     = pix_valid && pix_ready;
    assign frame_done = accept && at_last;
    assign ack_take   = frame_ack && full_q[rd_sel_q];

    raster_counter #(
        .ROWS (IMG_ROWS),
        .COLS (IMG_COLS)
    ) u_raster (
        .clk      (clk),
        .rst_n    (reset),
        .en_i     (accept),
        .row_o    (row),
        .col_o    (col),
        .last_c_o (at_last)
    );

    // Completion and ack can land together; they always target different banks.
    always_comb begin
        full_d    = full_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        len_err_d = len_err_q;
        if (frame_done) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = !wr_sel_q;
        end
        if (ack_take) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
        end
        if (accept && (pix_last != at_last)) begin
            len_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q    <= '0;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            len_err_q <= len_err_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < int'(IMG_ROWS); r++) begin
                    for (int c = 0; c < int'(IMG_COLS); c++) begin
                        bank_q[b][r][c] <= '0;
                    end
                end
            end
        end else if (accept) begin
            bank_q[wr_sel_q][row][col] <= pix_data;
        end
    end

`ifdef IMG_LOADER_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_count_q <= '0;
        end else if (ack_take) begin
            frame_count_q <= frame_count_q + FRAME_CNT_W'(1);
        end
    end

    assign frame_count = frame_count_q;
`endif

    assign frame_valid = full_q[rd_sel_q];
    assign image       = bank_q[rd_sel_q];
    assign len_err     = len_err_q;

endmodule

// File: tb/tb_image_stream_loader.sv
// Directed self-checking bench for image_stream_loader.
module tb_image_stream_loader;
    import lenet_pkg::*;

    logic   clk = 1'b0;
    logic   reset;
    pixel_t pix_data;
    logic   pix_valid;
    logic   pix_last;
    logic   pix_ready;
    frame_t image;
    logic   frame_valid;
    logic   frame_ack;
    logic   len_err;
`ifdef IMG_LOADER_FRAME_CNT_EN
    logic [31:0] frame_count;
`endif

    int checks = 0;
    int errors = 0;

    image_stream_loader dut (
        .clk         (clk),
        .reset       (reset),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_last    (pix_last),
        .pix_ready   (pix_ready),
        .image       (image),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .len_err     (len_err)
`ifdef IMG_LOADER_FRAME_CNT_EN
        ,
        .frame_count (frame_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pixel and hold it until accepted (bounded wait).
    task automatic push(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = last;
        while (!pix_ready && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $error("FAIL push_timeout: observed pix_ready 0 expected 1");
        end
        tick();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic push_range(input logic [31:0] base, input int first, input int last_idx,
                              input int marked);
        for (int i = first; i <= last_idx; i++) begin
            push(base + 32'(i), (i == marked));
        end
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        pix_data  = '0;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        frame_ack = 1'b0;
        #1;
        chk("rst_pix_ready", 32'(pix_ready), 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // 1: basic frame
        chk("t1_pix_ready", 32'(pix_ready), 1);
        chk("t1_fv_reset", 32'(frame_valid), 0);
        chk("t1_len_err_reset", 32'(len_err), 0);
        chk("t1_img00_reset", image[0][0], 0);
        chk("t1_img2727_reset", image[27][27], 0);
`ifdef IMG_LOADER_FRAME_CNT_EN
        chk("t1_fc_reset", frame_count, 0);
`endif
        push_range(32'd0, 0, 782, 783);
        chk("t1_fv_before_last", 32'(frame_valid), 0);
        push(32'd783, 1'b1);
        chk("t1_fv", 32'(frame_valid), 1);
        chk("t1_img00", image[0][0], 0);
        chk("t1_img57", image[5][7], 147);
        chk("t1_img270", image[27][0], 756);
        chk("t1_img2727", image[27][27], 783);
        chk("t1_len_err", 32'(len_err), 0);
        chk("t1_ready_after", 32'(pix_ready), 1);
        ack();
        chk("t1_fv_after_ack", 32'(frame_valid), 0);

        // 2: fill both banks, stall, then release
        push_range(32'd1000, 0, 783, 783);
        push_range(32'd2000, 0, 783, 783);
        chk("t2_ready_full", 32'(pix_ready), 0);
        chk("t2_fv", 32'(frame_valid), 1);
        chk("t2_imgA00", image[0][0], 1000);
        chk("t2_imgA2727", image[27][27], 1783);
        pix_valid = 1'b1;
        pix_data  = 32'd3000;
        for (int i = 0; i < 5; i++) tick();
        chk("t2_stall_ready", 32'(pix_ready), 0);
        chk("t2_stall_img", image[0][0], 1000);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("t2_imgB00", image[0][0], 2000);
        chk("t2_imgB2727", image[27][27], 2783);
        chk("t2_ready_freed", 32'(pix_ready), 1);
        chk("t2_fv_B", 32'(frame_valid), 1);
        pix_valid = 1'b0;
        push_range(32'd3000, 0, 783, 783);
        chk("t2_imgB_still", image[0][0], 2000);
        ack();
        chk("t2_imgC00", image[0][0], 3000);
        chk("t2_imgC2727", image[27][27], 3783);
        ack();
        chk("t2_fv_empty", 32'(frame_valid), 0);

        // 3: random duty with ignored acks on an empty output
        for (int i = 0; i < 784; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                frame_ack = 1'b1;
                tick();
                frame_ack = 1'b0;
            end
            push(32'd5000 + 32'(i), (i == 783));
            if (i < 783) chk("t3_no_spurious_fv", 32'(frame_valid), 0);
        end
        chk("t3_fv", 32'(frame_valid), 1);
        chk("t3_img00", image[0][0], 5000);
        chk("t3_img2727", image[27][27], 5783);
        ack();

        // 4: early pix_last sets sticky len_err
        push_range(32'd7000, 0, 498, 499);
        chk("t4_len_err_pre", 32'(len_err), 0);
        push(32'd7499, 1'b1);
        chk("t4_len_err_set", 32'(len_err), 1);
        chk("t4_fv_not_done", 32'(frame_valid), 0);
        push_range(32'd7000, 500, 783, 499);
        chk("t4_fv", 32'(frame_valid), 1);
        chk("t4_img2727", image[27][27], 7783);
        ack();
        push_range(32'd8000, 0, 783, 783);
        chk("t4_len_err_sticky", 32'(len_err), 1);
        chk("t4_img00_clean", image[0][0], 8000);
        ack();

        // 5: reset in mid-frame discards it
        push_range(32'd9000, 0, 399, 783);
        reset = 1'b0;
        #1;
        chk("t5_ready_in_reset", 32'(pix_ready), 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("t5_fv", 32'(frame_valid), 0);
        chk("t5_len_err", 32'(len_err), 0);
        chk("t5_img00", image[0][0], 0);
        chk("t5_img103", image[10][3], 0);
        chk("t5_ready", 32'(pix_ready), 1);
`ifdef IMG_LOADER_FRAME_CNT_EN
        chk("t5_fc_reset", frame_count, 0);
`endif
        push_range(32'd100, 0, 783, 783);
        chk("t5_fv_full", 32'(frame_valid), 1);
        chk("t5_img00_full", image[0][0], 100);
        chk("t5_img2727_full", image[27][27], 883);
        chk("t5_len_err_clean", 32'(len_err), 0);

        // 6: completion and ack in the same cycle
        push_range(32'd4000, 0, 782, 783);
        pix_valid = 1'b1;
        pix_data  = 32'd4783;
        pix_last  = 1'b1;
        frame_ack = 1'b1;
        #1;
        chk("t6_ready_pre", 32'(pix_ready), 1);
        chk("t6_fv_pre", 32'(frame_valid), 1);
        tick();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        frame_ack = 1'b0;
        chk("t6_fv", 32'(frame_valid), 1);
        chk("t6_img00", image[0][0], 4000);
        chk("t6_img2727", image[27][27], 4783);
        chk("t6_ready", 32'(pix_ready), 1);
        chk("t6_len_err", 32'(len_err), 0);
`ifdef IMG_LOADER_FRAME_CNT_EN
        chk("t6_frame_count", frame_count, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
